// File: rtl/pipelined_rv32i_core.sv
// Five-stage in-order RV32I integer core (ALU ops, LW, SW; no branches or stalls).
// Define FORWARDING_EN to forward EX operands from EX/MEM and MEM/WB.
module pipelined_rv32i_core (
    input  logic        clock,
    input  logic        reset,
    output logic [31:0] io_imem_PC,
    input  logic [31:0] io_imem_instr,
    output logic [31:0] io_dmem_addr,
    output logic [31:0] io_dmem_wData,
    output logic        io_dmem_wrEn,
    input  logic [31:0] io_dmem_rData,
    output logic [31:0] io_check_res
);
    logic [31:0] pc;
    logic [31:0] if_id_instr;

    logic        id_ex_wr, id_ex_load, id_ex_store, id_ex_use_imm, id_ex_alt;
    logic [2:0]  id_ex_funct3;
    logic [4:0]  id_ex_rd;
    logic [31:0] id_ex_a, id_ex_b, id_ex_imm;
`ifdef FORWARDING_EN
    logic [4:0]  id_ex_rs1, id_ex_rs2;
`endif

    logic        ex_mem_wr, ex_mem_load, ex_mem_store;
    logic [4:0]  ex_mem_rd;
    logic [31:0] ex_mem_alu, ex_mem_sdata;

    logic        mem_wb_wr;
    logic [4:0]  mem_wb_rd;
    logic [31:0] mem_wb_res;

    logic [31:0] regs [32];

    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [4:0]  rd, rs1, rs2;
    logic        dec_wr, dec_load, dec_store, dec_use_imm, dec_alt;
    logic [2:0]  dec_funct3;
    logic [31:0] dec_imm, rs1_val, rs2_val;

    assign opcode = if_id_instr[6:0];
    assign rd     = if_id_instr[11:7];
    assign funct3 = if_id_instr[14:12];
    assign rs1    = if_id_instr[19:15];
    assign rs2    = if_id_instr[24:20];
    assign funct7 = if_id_instr[31:25];

    // Anything not recognised leaves dec_wr/dec_store low and so retires as a NOP.
    always_comb begin
        dec_wr      = 1'b0;
        dec_load    = 1'b0;
        dec_store   = 1'b0;
        dec_use_imm = 1'b0;
        dec_alt     = 1'b0;
        dec_funct3  = funct3;
        dec_imm     = {{20{if_id_instr[31]}}, if_id_instr[31:20]};
        case (opcode)
            7'b0110011: begin
                if (funct7 == 7'h00 || (funct7 == 7'h20 && (funct3 == 3'b000 || funct3 == 3'b101))) begin
                    dec_wr  = 1'b1;
                    dec_alt = funct7[5];
                end
            end
            7'b0010011: begin
                dec_use_imm = 1'b1;
                if (funct3 == 3'b001) begin
                    dec_wr = (funct7 == 7'h00);
                end else if (funct3 == 3'b101) begin
                    dec_wr  = (funct7 == 7'h00 || funct7 == 7'h20);
                    dec_alt = funct7[5];
                end else begin
                    dec_wr = 1'b1;
                end
            end
            7'b0000011: begin
                if (funct3 == 3'b010) begin
                    dec_wr      = 1'b1;
                    dec_load    = 1'b1;
                    dec_use_imm = 1'b1;
                    dec_funct3  = 3'b000;
                end
            end
            7'b0100011: begin
                if (funct3 == 3'b010) begin
                    dec_store   = 1'b1;
                    dec_use_imm = 1'b1;
                    dec_funct3  = 3'b000;
                    dec_imm     = {{20{if_id_instr[31]}}, if_id_instr[31:25], if_id_instr[11:7]};
                end
            end
            default: ;
        endcase
        if (rd == 5'd0) dec_wr = 1'b0;
    end

    // A WB write to a register is visible to the ID read in the same cycle.
    assign rs1_val = (mem_wb_wr && mem_wb_rd == rs1) ? mem_wb_res : regs[rs1];
    assign rs2_val = (mem_wb_wr && mem_wb_rd == rs2) ? mem_wb_res : regs[rs2];

    logic [31:0] op_a, fwd_b, op_b, alu;

`ifdef FORWARDING_EN
    // EX/MEM is checked last so the youngest producer wins; loads there are not ready yet.
    always_comb begin
        op_a  = id_ex_a;
        fwd_b = id_ex_b;
        if (mem_wb_wr && mem_wb_rd == id_ex_rs1) op_a  = mem_wb_res;
        if (mem_wb_wr && mem_wb_rd == id_ex_rs2) fwd_b = mem_wb_res;
        if (ex_mem_wr && !ex_mem_load && ex_mem_rd == id_ex_rs1) op_a  = ex_mem_alu;
        if (ex_mem_wr && !ex_mem_load && ex_mem_rd == id_ex_rs2) fwd_b = ex_mem_alu;
    end
`else
    assign op_a  = id_ex_a;
    assign fwd_b = id_ex_b;
`endif

    assign op_b = id_ex_use_imm ? id_ex_imm : fwd_b;

    always_comb begin
        alu = '0;
        case (id_ex_funct3)
            3'b000:  alu = id_ex_alt ? op_a - op_b : op_a + op_b;
            3'b001:  alu = op_a << op_b[4:0];
            3'b010:  alu = {31'd0, $signed(op_a) < $signed(op_b)};
            3'b011:  alu = {31'd0, op_a < op_b};
            3'b100:  alu = op_a ^ op_b;
            3'b101:  alu = id_ex_alt ? 32'($signed(op_a) >>> op_b[4:0]) : op_a >> op_b[4:0];
            3'b110:  alu = op_a | op_b;
            default: alu = op_a & op_b;
        endcase
    end

    // Reset turns every stage into a bubble; an all-zero word decodes as a NOP.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc            <= '0;
            if_id_instr   <= '0;
            id_ex_wr      <= 1'b0;
            id_ex_load    <= 1'b0;
            id_ex_store   <= 1'b0;
            id_ex_use_imm <= 1'b0;
            id_ex_alt     <= 1'b0;
            id_ex_funct3  <= '0;
            id_ex_rd      <= '0;
            id_ex_a       <= '0;
            id_ex_b       <= '0;
            id_ex_imm     <= '0;
`ifdef FORWARDING_EN
            id_ex_rs1     <= '0;
            id_ex_rs2     <= '0;
`endif
            ex_mem_wr     <= 1'b0;
            ex_mem_load   <= 1'b0;
            ex_mem_store  <= 1'b0;
            ex_mem_rd     <= '0;
            ex_mem_alu    <= '0;
            ex_mem_sdata  <= '0;
            mem_wb_wr     <= 1'b0;
            mem_wb_rd     <= '0;
            mem_wb_res    <= '0;
        end else begin
            pc            <= pc + 32'd4;
            if_id_instr   <= io_imem_instr;
            id_ex_wr      <= dec_wr;
            id_ex_load    <= dec_load;
            id_ex_store   <= dec_store;
            id_ex_use_imm <= dec_use_imm;
            id_ex_alt     <= dec_alt;
            id_ex_funct3  <= dec_funct3;
            id_ex_rd      <= rd;
            id_ex_a       <= rs1_val;
            id_ex_b       <= rs2_val;
            id_ex_imm     <= dec_imm;
`ifdef FORWARDING_EN
            id_ex_rs1     <= rs1;
            id_ex_rs2     <= rs2;
`endif
            ex_mem_wr     <= id_ex_wr;
            ex_mem_load   <= id_ex_load;
            ex_mem_store  <= id_ex_store;
            ex_mem_rd     <= id_ex_rd;
            ex_mem_alu    <= alu;
            ex_mem_sdata  <= fwd_b;
            mem_wb_wr     <= ex_mem_wr;
            mem_wb_rd     <= ex_mem_rd;
            mem_wb_res    <= ex_mem_load ? io_dmem_rData : ex_mem_alu;
        end
    end

    // x0 is never written because decode drops writes with rd == 0.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (mem_wb_wr) begin
            regs[mem_wb_rd] <= mem_wb_res;
        end
    end

    assign io_imem_PC    = pc;
    assign io_dmem_addr  = {2'b00, ex_mem_alu[31:2]};
    assign io_dmem_wData = ex_mem_sdata;
    assign io_dmem_wrEn  = ex_mem_store;
    assign io_check_res  = mem_wb_wr ? mem_wb_res : 32'd0;
endmodule

// File: tb/tb_pipelined_rv32i_core.sv
// Testbench for pipelined_rv32i_core: directed program table, forwarding/spacing and
// mid-operation reset sequences, then random programs against an ISA-level model.
module tb_pipelined_rv32i_core;
    localparam logic [31:0] NOP = 32'h00000013;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] res;
        logic        st;
        logic [31:0] addr;
        logic [31:0] data;
    } vec_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] io_imem_PC, io_imem_instr, io_dmem_addr, io_dmem_wData, io_dmem_rData, io_check_res;
    logic        io_dmem_wrEn;

    logic [31:0] imem [256];
    logic [31:0] dmem [64];
    logic [31:0] expRes [256];
    logic        expSt [256];
    logic [31:0] expAddr [256];
    logic [31:0] expData [256];
    logic [31:0] mRegs [32];
    logic [31:0] mMem [64];
    vec_t        dirTable [22];
    int          vectors = 0;
    int          miscompares = 0;

    pipelined_rv32i_core dut (
        .clock        (clock),
        .reset        (reset),
        .io_imem_PC   (io_imem_PC),
        .io_imem_instr(io_imem_instr),
        .io_dmem_addr (io_dmem_addr),
        .io_dmem_wData(io_dmem_wData),
        .io_dmem_wrEn (io_dmem_wrEn),
        .io_dmem_rData(io_dmem_rData),
        .io_check_res (io_check_res)
    );

    always #5 clock = ~clock;

    assign io_imem_instr = imem[io_imem_PC[9:2]];
    assign io_dmem_rData = reset ? dmem[io_dmem_addr[5:0]] : 32'd0;

    always @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < 64; i++) dmem[i] <= 32'd0;
        end else if (io_dmem_wrEn) begin
            dmem[io_dmem_addr[5:0]] <= io_dmem_wData;
        end
    end

    function automatic logic [31:0] encR(input logic [6:0] f7, input logic [2:0] f3,
                                         input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        return {f7, rs2, rs1, f3, rd, 7'h33};
    endfunction

    function automatic logic [31:0] encI(input logic [2:0] f3, input logic [4:0] rd,
                                         input logic [4:0] rs1, input logic [11:0] imm);
        return {imm, rs1, f3, rd, 7'h13};
    endfunction

    function automatic logic [31:0] encL(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
        return {imm, rs1, 3'b010, rd, 7'h03};
    endfunction

    function automatic logic [31:0] encS(input logic [4:0] rs2, input logic [4:0] rs1, input logic [11:0] imm);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23};
    endfunction

    // Arithmetic of the integer ops by mnemonic group (alt selects SUB / SRA).
    function automatic logic [31:0] arith(input logic [2:0] f3, input logic alt,
                                          input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        sa = int'(a);
        sb = int'(b);
        case (f3)
            3'd0:    return alt ? a - b : a + b;
            3'd1:    return a << b[4:0];
            3'd2:    return (sa < sb) ? 32'd1 : 32'd0;
            3'd3:    return (a < b) ? 32'd1 : 32'd0;
            3'd4:    return a ^ b;
            3'd5:    return alt ? 32'(sa >>> b[4:0]) : a >> b[4:0];
            3'd6:    return a | b;
            default: return a & b;
        endcase
    endfunction

    task automatic checkOutput(input string name, input int cycle, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s cycle %0d: got %h, expected %h", name, cycle, actual, expected);
        end
    endtask

    task automatic clearProgram();
        for (int i = 0; i < 256; i++) begin
            imem[i]    = NOP;
            expRes[i]  = 32'd0;
            expSt[i]   = 1'b0;
            expAddr[i] = 32'd0;
            expData[i] = 32'd0;
        end
    endtask

    // Executes one instruction architecturally and records what WB/MEM must show for it.
    task automatic modelExec(input int idx);
        logic [31:0] ins, a, b, immI, immS, res, addr, data;
        logic [6:0]  opc, f7;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic        wr, st;
        ins  = imem[idx];
        opc  = ins[6:0];
        rd   = ins[11:7];
        f3   = ins[14:12];
        f7   = ins[31:25];
        a    = mRegs[ins[19:15]];
        b    = mRegs[ins[24:20]];
        immI = {{20{ins[31]}}, ins[31:20]};
        immS = {{20{ins[31]}}, ins[31:25], ins[11:7]};
        res = 32'd0; addr = 32'd0; data = 32'd0; wr = 1'b0; st = 1'b0;
        if (opc == 7'h33 && (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)))) begin
            res = arith(f3, f7[5], a, b);
            wr  = 1'b1;
        end else if (opc == 7'h13) begin
            if (f3 == 3'd1) begin
                wr = (f7 == 7'h00);
                res = arith(f3, 1'b0, a, immI);
            end else if (f3 == 3'd5) begin
                wr = (f7 == 7'h00 || f7 == 7'h20);
                res = arith(f3, f7[5], a, immI);
            end else begin
                wr = 1'b1;
                res = arith(f3, 1'b0, a, immI);
            end
        end else if (opc == 7'h03 && f3 == 3'd2) begin
            addr = (a + immI) >> 2;
            res  = mMem[addr[5:0]];
            wr   = 1'b1;
        end else if (opc == 7'h23 && f3 == 3'd2) begin
            addr = (a + immS) >> 2;
            data = b;
            st   = 1'b1;
            mMem[addr[5:0]] = b;
        end
        if (rd == 5'd0) wr = 1'b0;
        if (wr) mRegs[rd] = res;
        expRes[idx]  = wr ? res : 32'd0;
        expSt[idx]   = st;
        expAddr[idx] = addr;
        expData[idx] = data;
    endtask

    task automatic modelRun(input int n);
        for (int r = 0; r < 32; r++) mRegs[r] = 32'd0;
        for (int m = 0; m < 64; m++) mMem[m] = 32'd0;
        for (int i = 0; i < n; i++) modelExec(i);
    endtask

    // Random program over x0..x7; a read too close to its producer becomes a NOP.
    task automatic genRandom(input int n);
        int lastW [32];
        bit lastLd [32];
        for (int r = 0; r < 32; r++) begin
            lastW[r]  = -100;
            lastLd[r] = 1'b0;
        end
        clearProgram();
        for (int idx = 0; idx < n; idx++) begin
            logic [31:0] ins;
            logic [4:0]  rd, rs1, rs2, r;
            logic [2:0]  f3;
            logic [11:0] imm;
            bit          useA, useB, wr, ld, ok, used;
            int          need;
            rd   = 5'($urandom_range(0, 7));
            rs1  = 5'($urandom_range(0, 7));
            rs2  = 5'($urandom_range(0, 7));
            f3   = 3'($urandom_range(0, 7));
            imm  = 12'($urandom);
            useA = 1'b0; useB = 1'b0; wr = 1'b0; ld = 1'b0;
            case ($urandom_range(0, 9))
                0, 1, 2, 3: begin
                    ins  = encR(((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00,
                                f3, rd, rs1, rs2);
                    useA = 1'b1; useB = 1'b1; wr = 1'b1;
                end
                4, 5, 6: begin
                    if (f3 == 3'd1) imm[11:5] = 7'h00;
                    else if (f3 == 3'd5) imm[11:5] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
                    ins  = encI(f3, rd, rs1, imm);
                    useA = 1'b1; wr = 1'b1;
                end
                7: begin
                    ins = encL(rd, 5'd0, 12'(4 * $urandom_range(0, 15)));
                    wr = 1'b1; ld = 1'b1;
                end
                8: begin
                    ins  = encS(rs2, 5'd0, 12'(4 * $urandom_range(0, 15)));
                    useB = 1'b1;
                end
                default: begin
                    case ($urandom_range(0, 3))
                        0:       ins = encR(7'h01, f3, rd, rs1, rs2);
                        1:       ins = {25'($urandom), 7'h7F};
                        2:       ins = 32'h0;
                        default: ins = {imm, rs1, 3'b000, rd, 7'h03};
                    endcase
                end
            endcase
            ok = 1'b1;
            for (int s = 0; s < 2; s++) begin
                r    = (s == 0) ? rs1 : rs2;
                used = (s == 0) ? useA : useB;
`ifdef FORWARDING_EN
                need = lastLd[r] ? 2 : 1;
`else
                need = 3;
`endif
                if (used && r != 5'd0 && (idx - lastW[r]) < need) ok = 1'b0;
            end
            if (!ok) begin
                ins = NOP;
            end else if (wr && rd != 5'd0) begin
                lastW[rd]  = idx;
                lastLd[rd] = ld;
            end
            imem[idx] = ins;
        end
        modelRun(n);
    endtask

    // Holds reset two cycles, releases it, then checks every cycle against the expected arrays.
    task automatic applyStimulus(input int cycles);
        logic [31:0] er;
        logic        es;
        reset = 1'b0;
        @(negedge clock);
        #1;
        checkOutput("reset_pc", -1, io_imem_PC, 32'd0);
        checkOutput("reset_check_res", -1, io_check_res, 32'd0);
        checkOutput("reset_wrEn", -1, {31'd0, io_dmem_wrEn}, 32'd0);
        checkOutput("reset_addr", -1, io_dmem_addr, 32'd0);
        checkOutput("reset_wData", -1, io_dmem_wData, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        for (int k = 0; k < cycles; k++) begin
            #1;
            checkOutput("pc", k, io_imem_PC, 32'(4 * k));
            er = (k >= 4) ? expRes[k - 4] : 32'd0;
            es = (k >= 3) ? expSt[k - 3] : 1'b0;
            checkOutput("check_res", k, io_check_res, er);
            checkOutput("wrEn", k, {31'd0, io_dmem_wrEn}, {31'd0, es});
            if (es) begin
                checkOutput("store_addr", k, io_dmem_addr, expAddr[k - 3]);
                checkOutput("store_wData", k, io_dmem_wData, expData[k - 3]);
            end
            @(negedge clock);
        end
    endtask

    initial begin
        dirTable[0]  = '{encI(3'd0, 5'd1, 5'd0, 12'd5),           32'd5,          1'b0, 32'd0, 32'd0};
        dirTable[1]  = '{encI(3'd0, 5'd2, 5'd0, 12'hFFD),         32'hFFFFFFFD,   1'b0, 32'd0, 32'd0};
        dirTable[2]  = '{NOP,                                     32'd0,          1'b0, 32'd0, 32'd0};
        dirTable[3]  = '{NOP,                                     32'd0,          1'b0, 32'd0, 32'd0};
        dirTable[4]  = '{encR(7'h00, 3'd0, 5'd3, 5'd1, 5'd2),     32'd2,          1'b0, 32'd0, 32'd0};
        dirTable[5]  = '{encR(7'h20, 3'd0, 5'd4, 5'd1, 5'd2),     32'd8,          1'b0, 32'd0, 32'd0};
        dirTable[6]  = '{encR(7'h00, 3'd2, 5'd5, 5'd2, 5'd1),     32'd1,          1'b0, 32'd0, 32'd0};
        dirTable[7]  = '{encR(7'h00, 3'd3, 5'd6, 5'd2, 5'd1),     32'd0,          1'b0, 32'd0, 32'd0};
        dirTable[8]  = '{encS(5'd1, 5'd0, 12'd8),                 32'd0,          1'b1, 32'd2, 32'd5};
        dirTable[9]  = '{encL(5'd7, 5'd0, 12'd8),                 32'd5,          1'b0, 32'd0, 32'd0};
        dirTable[10] = '{encI(3'd0, 5'd0, 5'd0, 12'd9),           32'd0,          1'b0, 32'd0, 32'd0};
        dirTable[11] = '{32'h00000000,                            32'd0,          1'b0, 32'd0, 32'd0};
        dirTable[12] = '{encI(3'd6, 5'd9, 5'd0, 12'h7F0),         32'h000007F0,   1'b0, 32'd0, 32'd0};
        dirTable[13] = '{encI(3'd5, 5'd10, 5'd2, 12'h41F),        32'hFFFFFFFF,   1'b0, 32'd0, 32'd0};
        dirTable[14] = '{encI(3'd1, 5'd11, 5'd1, 12'd31),         32'h80000000,   1'b0, 32'd0, 32'd0};
        dirTable[15] = '{encI(3'd3, 5'd12, 5'd2, 12'hFFF),        32'd1,          1'b0, 32'd0, 32'd0};
        dirTable[16] = '{encI(3'd2, 5'd13, 5'd2, 12'hFFC),        32'd0,          1'b0, 32'd0, 32'd0};
        dirTable[17] = '{encR(7'h00, 3'd0, 5'd8, 5'd7, 5'd0),     32'd5,          1'b0, 32'd0, 32'd0};
        dirTable[18] = '{encI(3'd4, 5'd14, 5'd1, 12'hFFF),        32'hFFFFFFFA,   1'b0, 32'd0, 32'd0};
        dirTable[19] = '{NOP,                                     32'd0,          1'b0, 32'd0, 32'd0};
        dirTable[20] = '{encR(7'h00, 3'd0, 5'd15, 5'd11, 5'd11),  32'd0,          1'b0, 32'd0, 32'd0};
        dirTable[21] = '{encR(7'h00, 3'd5, 5'd16, 5'd2, 5'd1),    32'h07FFFFFF,   1'b0, 32'd0, 32'd0};

        $display("[TB] directed program table");
        clearProgram();
        for (int i = 0; i < 22; i++) begin
            imem[i]    = dirTable[i].instr;
            expRes[i]  = dirTable[i].res;
            expSt[i]   = dirTable[i].st;
            expAddr[i] = dirTable[i].addr;
            expData[i] = dirTable[i].data;
        end
        applyStimulus(26);

        $display("[TB] dependent ADDI pair");
        clearProgram();
        imem[0] = encI(3'd0, 5'd1, 5'd0, 12'd7);
        expRes[0] = 32'd7;
`ifdef FORWARDING_EN
        imem[1] = encI(3'd0, 5'd1, 5'd1, 12'd1);
        expRes[1] = 32'd8;
        imem[2] = encS(5'd1, 5'd0, 12'd4);
        expSt[2] = 1'b1; expAddr[2] = 32'd1; expData[2] = 32'd8;
        imem[3] = encL(5'd2, 5'd0, 12'd4);
        expRes[3] = 32'd8;
        imem[5] = encI(3'd0, 5'd3, 5'd2, 12'd1);
        expRes[5] = 32'd9;
        imem[6] = encR(7'h00, 3'd0, 5'd4, 5'd3, 5'd3);
        expRes[6] = 32'd18;
`else
        imem[3] = encI(3'd0, 5'd1, 5'd1, 12'd1);
        expRes[3] = 32'd8;
`endif
        applyStimulus(14);

        $display("[TB] reset during a store");
        clearProgram();
        imem[0] = encI(3'd0, 5'd1, 5'd0, 12'd5);
        imem[3] = encS(5'd1, 5'd0, 12'd4);
        reset = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        repeat (6) @(negedge clock);
        #1;
        checkOutput("midrst_pre_wrEn", 6, {31'd0, io_dmem_wrEn}, 32'd1);
        checkOutput("midrst_pre_addr", 6, io_dmem_addr, 32'd1);
        #2 reset = 1'b0;
        #1;
        checkOutput("midrst_wrEn", 6, {31'd0, io_dmem_wrEn}, 32'd0);
        checkOutput("midrst_check_res", 6, io_check_res, 32'd0);
        checkOutput("midrst_pc", 6, io_imem_PC, 32'd0);
        checkOutput("midrst_addr", 6, io_dmem_addr, 32'd0);
        checkOutput("midrst_wData", 6, io_dmem_wData, 32'd0);
        clearProgram();
        imem[0] = encI(3'd0, 5'd3, 5'd1, 12'd1);
        expRes[0] = 32'd1;
        applyStimulus(6);

        for (int run = 0; run < 3; run++) begin
            $display("[TB] random program %0d", run);
            genRandom(200);
            applyStimulus(204);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
